// File: rtl/if_stage_pkg.sv
// Shared CPU package: fetch-stage FSM encoding and reset defaults.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: request/wait/hold FSM feeding the internal F/D register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        stall,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        fetch_busy
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  buf_r;
  logic         f_ready_s;
  logic         transfer_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; REQ deliberately ignores stall so fetch overlaps a frozen D
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_REQ: begin
        if (im_gnt) state_nxt_s = ST_WAIT;
        else        state_nxt_s = ST_REQ;
      end
      ST_WAIT: begin
        if (im_rvalid && stall)  state_nxt_s = ST_HOLD;
        else if (im_rvalid)      state_nxt_s = ST_REQ;
        else                     state_nxt_s = ST_WAIT;
      end
      ST_HOLD: begin
        if (stall) state_nxt_s = ST_HOLD;
        else       state_nxt_s = ST_REQ;
      end
      default: state_nxt_s = ST_REQ;
    endcase
  end

  // Output decode
  always_comb begin
    im_req     = 1'b0;
    f_ready_s  = 1'b0;
    case (state_r)
      ST_REQ:  im_req    = 1'b1;
      ST_WAIT: f_ready_s = im_rvalid;
      ST_HOLD: f_ready_s = 1'b1;
      default: im_req    = 1'b0;
    endcase
    fetch_busy = ~f_ready_s;
    transfer_s = f_ready_s & ~stall;
    im_addr    = word_align(F_PC);
  end

  // PC and F/D register; D never takes a bubble, it only changes when F delivers
  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC    <= RESET_PC;
      D_PC    <= RESET_PC;
      D_Instr <= NOP_INSTR;
      buf_r   <= 32'h0000_0000;
    end else if (transfer_s) begin
      D_Instr <= (state_r == ST_HOLD) ? buf_r : im_rdata;
      D_PC    <= F_PC;
      F_PC    <= NPC;
    end else if ((state_r == ST_WAIT) && im_rvalid && stall) begin
      buf_r   <= im_rdata;
    end else begin
      buf_r   <= buf_r;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory responder + abstract fetch model, scoreboard monitor.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] NPC = 32'h0;
  logic        stall = 1'b0;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        im_req;
  logic [31:0] im_addr, F_PC, D_PC, D_Instr;
  logic        fetch_busy;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .NPC(NPC), .stall(stall),
    .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .im_req(im_req), .im_addr(im_addr), .F_PC(F_PC), .D_PC(D_PC),
    .D_Instr(D_Instr), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
  } cyc_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
  } xfer_exp_t;

  cyc_exp_t  cyc_q[$];
  xfer_exp_t xq[$];
  int n_chk = 0;
  int n_fail = 0;

  // Memory model: fetch-phase bookkeeping of the bench's responder
  typedef enum int {PH_GNT, PH_OUT, PH_HOLD} phase_e;
  phase_e      phase = PH_GNT;
  int          cnt = 0;
  logic        model_ok = 1'b0;
  logic [31:0] m_fpc = RST_PC, m_dpc = RST_PC, m_dinstr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_3000) return 32'h2408_0005;
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, record expectations, then advance the model across the edge
  task automatic do_cycle(input logic st, input logic gn, input int dly,
                          input logic [31:0] npc_v, input logic rs);
    cyc_exp_t e;
    logic xfer;
    reset = rs; stall = st; NPC = npc_v;
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = $urandom;
    case (phase)
      PH_GNT: im_gnt = gn;
      PH_OUT: if (cnt == 0) begin im_rvalid = 1'b1; im_rdata = mem_word(m_fpc); end
      default: ;
    endcase
    if (model_ok) begin
      e.req = (phase == PH_GNT);
      e.addr = {m_fpc[31:2], 2'b00};
      e.busy = !(im_rvalid || phase == PH_HOLD);
      e.fpc = m_fpc; e.dpc = m_dpc; e.dinstr = m_dinstr;
      cyc_q.push_back(e);
    end
    xfer = model_ok && !rs && !st && (im_rvalid || phase == PH_HOLD);
    @(posedge clk); #1;
    if (rs) begin
      phase = PH_GNT; m_fpc = RST_PC; m_dpc = RST_PC; m_dinstr = 32'h0; model_ok = 1'b1;
    end else if (xfer) begin
      xq.push_back('{m_fpc, mem_word(m_fpc), npc_v});
      m_dpc = m_fpc; m_dinstr = mem_word(m_fpc); m_fpc = npc_v; phase = PH_GNT;
    end else begin
      case (phase)
        PH_GNT: if (gn) begin phase = PH_OUT; cnt = dly - 1; end
        PH_OUT: if (cnt == 0) phase = PH_HOLD; else cnt--;
        default: ;
      endcase
    end
  endtask

  // Monitor: per-cycle status scoreboard, plus D contents after each observed transfer
  initial begin
    cyc_exp_t  e;
    xfer_exp_t x;
    logic      chk_next = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        if (xq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL xfer_unexpected: DUT transferred with no expected fetch at %0t", $time);
        end else begin
          x = xq.pop_front();
          chk("xfer_D_PC", D_PC, x.pc);
          chk("xfer_D_Instr", D_Instr, x.instr);
          chk("xfer_F_PC", F_PC, x.npc);
        end
      end
      chk_next = 1'b0;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("im_req", {31'h0, im_req}, {31'h0, e.req});
        if (e.req) chk("im_addr", im_addr, e.addr);
        chk("fetch_busy", {31'h0, fetch_busy}, {31'h0, e.busy});
        chk("F_PC", F_PC, e.fpc);
        chk("D_PC", D_PC, e.dpc);
        chk("D_Instr", D_Instr, e.dinstr);
        chk_next = !reset && !fetch_busy && !stall;
      end
    end
  end

  initial begin
    int rcnt;
    #1;
    do_cycle(1'b0, 1'b0, 1, 32'h0, 1'b1);
    do_cycle(1'b0, 1'b0, 1, 32'h0, 1'b1);
    // Basic fetch: grant, one-cycle response
    do_cycle(1'b0, 1'b1, 1, 32'h0000_3004, 1'b0);
    do_cycle(1'b0, 1'b0, 1, 32'h0000_3004, 1'b0);
    // Grant withheld for 3 cycles, then response lands under a 4-cycle stall
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1, 32'hDEAD_0000, 1'b0);
    do_cycle(1'b0, 1'b1, 2, 32'hDEAD_0004, 1'b0);
    do_cycle(1'b1, 1'b0, 1, 32'hDEAD_0008, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 1, 32'hBEEF_0000, 1'b0);
    do_cycle(1'b0, 1'b0, 1, 32'h0000_3010, 1'b0);
    // Misaligned NPC
    do_cycle(1'b0, 1'b1, 1, 32'h0, 1'b0);
    do_cycle(1'b0, 1'b0, 1, 32'h0000_3006, 1'b0);
    do_cycle(1'b0, 1'b0, 1, 32'h0, 1'b0);
    // Reset while a response is outstanding
    do_cycle(1'b0, 1'b1, 3, 32'h0, 1'b0);
    do_cycle(1'b0, 1'b0, 1, 32'h0, 1'b1);
    do_cycle(1'b0, 1'b0, 1, 32'h0, 1'b0);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rcnt = $urandom_range(199, 0);
      do_cycle(($urandom_range(99, 0) < 40), ($urandom_range(99, 0) < 60),
               $urandom_range(3, 1), $urandom, (rcnt == 0));
    end
    do_cycle(1'b1, 1'b0, 1, 32'h0, 1'b0);
    @(negedge clk); @(negedge clk);
    n_chk++;
    if (cyc_q.size() != 0 || xq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d cycle and %0d transfer expectations left, expected 0",
               cyc_q.size(), xq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
